cva6_cap_regfile: RTL and testbench



---
 rtl/config_pkg.sv | 12 +
 rtl/cva6_cap_regfile_if.sv | 36 +++
 rtl/cva6_cap_regfile.sv | 179 +++++++++++++++++
 tb/tb_cva6_cap_regfile.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// Core configuration record shared by CVA6 blocks.
// cva6_cfg_empty is the baseline used when no core configuration is supplied.
package config_pkg;

  typedef struct packed {
    bit          CheriPresent;   // capability valid bits and bulk-clear engine present
    int unsigned NrCommitPorts;  // number of commit-stage write ports
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{CheriPresent: 1'b1, NrCommitPorts: 32'd2};

endpackage

// File: rtl/cva6_cap_regfile_if.sv
// Port bundle for cva6_cap_regfile: operand read ports, commit write ports,
// and the bulk-clear request/status handshake.
//   slave  : the register file
//   master : the issue/commit logic driving it
interface cva6_cap_regfile_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned NR_READ_PORTS  = 2,
  parameter int unsigned NR_WRITE_PORTS = 2
);
  localparam int unsigned NUM_WORDS = 1 << ADDR_WIDTH;

  logic                                      test_en_i;
  logic [NR_READ_PORTS-1:0][ADDR_WIDTH-1:0]  raddr_i;
  logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]  rdata_o;
  logic [NR_READ_PORTS-1:0]                  rvalid_o;
  logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0] waddr_i;
  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_i;
  logic [NR_WRITE_PORTS-1:0]                 we_i;
  logic                                      clr_valid_i;
  logic                                      clr_ready_o;
  logic [NUM_WORDS-1:0]                      clr_mask_i;
  logic                                      clr_busy_o;
  logic                                      clr_done_o;

  modport slave (
    input  test_en_i, raddr_i, waddr_i, wdata_i, we_i, clr_valid_i, clr_mask_i,
    output rdata_o, rvalid_o, clr_ready_o, clr_busy_o, clr_done_o
  );

  modport master (
    output test_en_i, raddr_i, waddr_i, wdata_i, we_i, clr_valid_i, clr_mask_i,
    input  rdata_o, rvalid_o, clr_ready_o, clr_busy_o, clr_done_o
  );

endinterface

// File: rtl/cva6_cap_regfile.sv
// Flip-flop register file with per-register capability valid bits and a
// sequenced bulk-clear engine. A clear hides the masked registers from reads
// immediately after acceptance, then zeroes storage CLR_PER_CYCLE registers
// per cycle over NUM_WORDS/CLR_PER_CYCLE cycles.
//
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : raddr_i/rdata_o/rvalid_o read ports, waddr_i/wdata_i/we_i
//                   write ports, clr_valid_i/clr_ready_o/clr_mask_i request,
//                   clr_busy_o/clr_done_o sweep status, test_en_i (no effect)
//
// Build option: define CAP_RF_WFWD_EN to forward same-cycle write data to
// matching read ports; otherwise reads see pre-edge state only.
module cva6_cap_regfile #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg        = config_pkg::cva6_cfg_empty,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           ADDR_WIDTH     = 5,
  parameter int unsigned           NR_READ_PORTS  = 2,
  parameter int unsigned           NR_WRITE_PORTS = CVA6Cfg.NrCommitPorts,
  parameter int unsigned           CLR_PER_CYCLE  = 8,
  parameter bit                    ZERO_REG_ZERO  = 1'b0
) (
  input logic               clk_i,
  input logic               rst_ni,
  cva6_cap_regfile_if.slave bus
);

  localparam int unsigned NUM_WORDS  = 1 << ADDR_WIDTH;
  localparam int unsigned NUM_GROUPS = NUM_WORDS / CLR_PER_CYCLE;
  localparam int unsigned GPTR_W     = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] mem_q;
  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] wr_data;
  logic [NUM_WORDS-1:0]                 wr_en;
  logic [NUM_WORDS-1:0]                 vis;      // register readable (valid and not pending)
  logic [NUM_WORDS-1:0]                 clr_hit;  // register zeroed by the sweep this cycle

  logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0] rdata;
  logic [NR_READ_PORTS-1:0]                 rvalid;

  logic unused_test_en;
  assign unused_test_en = bus.test_en_i;

  // Per-register write decode; later ports overwrite earlier ones so the
  // highest-indexed port wins on an address collision.
  always_comb begin
    wr_en   = '0;
    wr_data = '0;
    for (int unsigned j = 0; j < NR_WRITE_PORTS; j++) begin
      if (bus.we_i[j] && !(ZERO_REG_ZERO && (bus.waddr_i[j] == '0))) begin
        wr_en[bus.waddr_i[j]]   = 1'b1;
        wr_data[bus.waddr_i[j]] = bus.wdata_i[j];
      end
    end
  end

  // Data storage: writes take priority over the sweep (clr_hit excludes them).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
        if (wr_en[i]) begin
          mem_q[i] <= wr_data[i];
        end else if (clr_hit[i]) begin
          mem_q[i] <= '0;
        end
      end
    end
  end

  if (CVA6Cfg.CheriPresent) begin : g_cap
    typedef enum logic {CLR_IDLE, CLR_SWEEP} clr_state_e;

    clr_state_e           state_q, state_d;
    logic [GPTR_W-1:0]    gptr_q, gptr_d;
    logic                 done_q, done_d;
    logic                 accept;
    logic [NUM_WORDS-1:0] v_q, pend_q, grp_sel;

    // Registers belonging to the group currently addressed by the sweep.
    for (genvar i = 0; i < NUM_WORDS; i++) begin : g_grp
      assign grp_sel[i] = (gptr_q == GPTR_W'(i / CLR_PER_CYCLE));
    end

    assign clr_hit = {NUM_WORDS{state_q == CLR_SWEEP}} & grp_sel & pend_q & ~wr_en;
    assign vis     = v_q & ~pend_q;

    // Clear sequencer next-state.
    always_comb begin
      state_d = state_q;
      gptr_d  = gptr_q;
      done_d  = 1'b0;
      accept  = 1'b0;
      unique case (state_q)
        CLR_IDLE: begin
          if (bus.clr_valid_i) begin
            accept  = 1'b1;
            gptr_d  = '0;
            state_d = CLR_SWEEP;
          end
        end
        CLR_SWEEP: begin
          gptr_d = gptr_q + 1'b1;
          if (gptr_q == GPTR_W'(NUM_GROUPS - 1)) begin
            gptr_d  = '0;
            done_d  = 1'b1;
            state_d = CLR_IDLE;
          end
        end
        default: state_d = CLR_IDLE;
      endcase
    end

    // Sequencer, valid and pending state. A write always revalidates its
    // register and drops any pending clear on it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= CLR_IDLE;
        gptr_q  <= '0;
        done_q  <= 1'b0;
        v_q     <= '0;
        pend_q  <= '0;
      end else begin
        state_q <= state_d;
        gptr_q  <= gptr_d;
        done_q  <= done_d;
        v_q     <= wr_en | (v_q & ~clr_hit);
        if (accept) begin
          pend_q <= bus.clr_mask_i & ~wr_en;
        end else begin
          pend_q <= pend_q & ~wr_en & ~clr_hit;
        end
      end
    end

    assign bus.clr_ready_o = (state_q == CLR_IDLE);
    assign bus.clr_busy_o  = (state_q == CLR_SWEEP);
    assign bus.clr_done_o  = done_q;
  end else begin : g_nocap
    logic unused_clr;
    assign unused_clr      = bus.clr_valid_i ^ (^bus.clr_mask_i);
    assign vis             = '1;
    assign clr_hit         = '0;
    assign bus.clr_ready_o = 1'b0;
    assign bus.clr_busy_o  = 1'b0;
    assign bus.clr_done_o  = 1'b0;
  end

  // Read ports: masked by visibility, optionally overridden by same-cycle writes.
  always_comb begin
    rdata  = '0;
    rvalid = '0;
    for (int unsigned p = 0; p < NR_READ_PORTS; p++) begin
      if (vis[bus.raddr_i[p]]) begin
        rdata[p]  = mem_q[bus.raddr_i[p]];
        rvalid[p] = 1'b1;
      end
`ifdef CAP_RF_WFWD_EN
      for (int unsigned j = 0; j < NR_WRITE_PORTS; j++) begin
        if (bus.we_i[j] && (bus.waddr_i[j] == bus.raddr_i[p]) &&
            !(ZERO_REG_ZERO && (bus.raddr_i[p] == '0))) begin
          rdata[p]  = bus.wdata_i[j];
          rvalid[p] = 1'b1;
        end
      end
`endif
      // Hardwired null register.
      if (ZERO_REG_ZERO && (bus.raddr_i[p] == '0)) begin
        rdata[p]  = '0;
        rvalid[p] = 1'b0;
      end
    end
  end

  assign bus.rdata_o  = rdata;
  assign bus.rvalid_o = rvalid;

endmodule

// File: tb/tb_cva6_cap_regfile.sv
// Self-checking bench for cva6_cap_regfile (32 words, 2R/2W, 8 per sweep cycle).
// Read expectations come from a visible-state model and are queued when the
// read address is driven, then popped and compared once the port settles.
module tb_cva6_cap_regfile;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned NRP = 2;
  localparam int unsigned NWP = 2;
  localparam int          NW  = 32;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  cva6_cap_regfile_if #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NR_READ_PORTS(NRP), .NR_WRITE_PORTS(NWP)
  ) bus ();

  cva6_cap_regfile #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NR_READ_PORTS(NRP), .NR_WRITE_PORTS(NWP),
    .CLR_PER_CYCLE(8), .ZERO_REG_ZERO(1'b0)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  typedef struct {
    int          port;
    int          addr;
    logic [31:0] data;
    logic        valid;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_data[NW];
  logic        m_val[NW];
  logic        clr_pend;
  logic [31:0] clr_pmask;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fill_val(input int a);
    return 32'hA5A5_0000 | 32'(a * 257);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NW; i++) begin
      m_data[i] = '0;
      m_val[i]  = 1'b0;
    end
    clr_pend = 1'b0;
  endtask

  task automatic rd_exp(input int p, input int a, input logic [31:0] d, input logic v);
    exp_t e;
    bus.raddr_i[p] = AW'(a);
    e.port = p; e.addr = a; e.data = d; e.valid = v;
    sb.push_back(e);
  endtask

  task automatic rd(input int p, input int a);
    rd_exp(p, a, m_data[a], m_val[a]);
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("rdata p%0d r%0d", e.port, e.addr), 64'(bus.rdata_o[e.port]), 64'(e.data));
      check($sformatf("rvalid p%0d r%0d", e.port, e.addr), 64'(bus.rvalid_o[e.port]), 64'(e.valid));
    end
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d);
    bus.we_i[p]    = 1'b1;
    bus.waddr_i[p] = AW'(a);
    bus.wdata_i[p] = d;
  endtask

  // Advance one edge and apply the accepted clear, then the writes, to the model.
  task automatic step();
    @(posedge clk_i);
    #1;
    if (clr_pend) begin
      for (int i = 0; i < NW; i++) begin
        if (clr_pmask[i]) begin
          m_data[i] = '0;
          m_val[i]  = 1'b0;
        end
      end
      clr_pend        = 1'b0;
      bus.clr_valid_i = 1'b0;
    end
    for (int p = 0; p < NWP; p++) begin
      if (bus.we_i[p]) begin
        m_data[bus.waddr_i[p]] = bus.wdata_i[p];
        m_val[bus.waddr_i[p]]  = 1'b1;
      end
    end
    bus.we_i = '0;
  endtask

  task automatic clr_req(input logic [31:0] mask);
    check("clr_ready before request", 64'(bus.clr_ready_o), 64'(1));
    bus.clr_valid_i = 1'b1;
    bus.clr_mask_i  = mask;
    clr_pend        = 1'b1;
    clr_pmask       = mask;
  endtask

  // Called just after the accepting edge; optional write on sweep cycle wr_cyc.
  task automatic wait_sweep(input int wr_cyc, input int wr_a, input logic [31:0] wr_d);
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at  = -1;
    for (int i = 0; i < 16; i++) begin
      if (bus.clr_busy_o) busy_cnt++;
      if (bus.clr_done_o) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
        check("clr_ready with done", 64'(bus.clr_ready_o), 64'(1));
      end
      if (done_at >= 0 && i >= done_at + 2) break;
      if (i == wr_cyc) wr(0, wr_a, wr_d);
      rd(0, (i * 7) % NW);
      rd(1, (i * 7 + 3) % NW);
      drain();
      step();
    end
    check("busy cycles", 64'(busy_cnt), 64'(4));
    check("done pulses", 64'(done_cnt), 64'(1));
    check("done position", 64'(done_at), 64'(4));
  endtask

  task automatic read_all();
    for (int a = 0; a < NW; a += 2) begin
      rd(0, a);
      rd(1, a + 1);
      drain();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.test_en_i   = 1'b0;
    bus.raddr_i     = '0;
    bus.waddr_i     = '0;
    bus.wdata_i     = '0;
    bus.we_i        = '0;
    bus.clr_valid_i = 1'b0;
    bus.clr_mask_i  = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    check("reset clr_ready", 64'(bus.clr_ready_o), 64'(1));
    check("reset clr_busy", 64'(bus.clr_busy_o), 64'(0));
    check("reset clr_done", 64'(bus.clr_done_o), 64'(0));
    read_all();
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();

    // Single write, then read-back (same cycle depends on forwarding)
    wr(0, 5, 32'hDEAD_BEEF);
`ifdef CAP_RF_WFWD_EN
    rd_exp(0, 5, 32'hDEAD_BEEF, 1'b1);
`else
    rd_exp(0, 5, 32'h0, 1'b0);
`endif
    drain();
    step();
    rd_exp(0, 5, 32'hDEAD_BEEF, 1'b1);
    drain();

    // Two ports on r7: higher port wins
    wr(0, 7, 32'h11);
    wr(1, 7, 32'h22);
`ifdef CAP_RF_WFWD_EN
    rd_exp(1, 7, 32'h22, 1'b1);
`else
    rd_exp(1, 7, 32'h0, 1'b0);
`endif
    drain();
    step();
    rd_exp(0, 7, 32'h22, 1'b1);
    drain();

    // Fill r1..r31
    for (int a = 1; a < NW; a += 2) begin
      wr(0, a, fill_val(a));
      if (a + 1 < NW) wr(1, a + 1, fill_val(a + 1));
      step();
    end
    read_all();

    // Clear r8..r15
    clr_req(32'h0000_FF00);
    step();
    check("busy after accept", 64'(bus.clr_busy_o), 64'(1));
    check("ready after accept", 64'(bus.clr_ready_o), 64'(0));
    rd_exp(0, 8, 32'h0, 1'b0);
    rd_exp(1, 16, fill_val(16), 1'b1);
    drain();
    wait_sweep(-1, 0, 32'h0);
    read_all();

    // Clear all but r0 with a write to r20 during the sweep
    clr_req(32'hFFFF_FFFE);
    step();
    wait_sweep(1, 20, 32'h55);
    rd_exp(0, 20, 32'h55, 1'b1);
    rd_exp(1, 15, 32'h0, 1'b0);
    drain();
    read_all();

    // Reset in the middle of a sweep
    wr(0, 3, 32'h3333);
    wr(1, 9, 32'h9999);
    step();
    clr_req(32'hFFFF_FFFF);
    step();
    check("busy mid-sweep", 64'(bus.clr_busy_o), 64'(1));
    step();
    step();
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    check("busy in reset", 64'(bus.clr_busy_o), 64'(0));
    check("ready in reset", 64'(bus.clr_ready_o), 64'(1));
    check("done in reset", 64'(bus.clr_done_o), 64'(0));
    rd(0, 3);
    rd(1, 9);
    drain();
    step();
    rst_ni = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("no done after reset", 64'(bus.clr_done_o), 64'(0));
      check("idle after reset", 64'(bus.clr_busy_o), 64'(0));
      step();
    end
    wr(0, 9, 32'h99);
    step();
    rd(1, 9);
    drain();
    clr_req(32'h0000_0200);
    step();
    check("busy after re-accept", 64'(bus.clr_busy_o), 64'(1));
    rd(0, 9);
    drain();
    wait_sweep(-1, 0, 32'h0);
    read_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
